// File: rtl/edge_frame_sched.sv
// Frame sequencer for a combinational 3x3 edge kernel: clears the result frame,
// raster-streams the source frame, builds the sliding window and writes back results.
module edge_frame_sched #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [7:0]        ar11,
  output logic [7:0]        ar12,
  output logic [7:0]        ar13,
  output logic [7:0]        ar21,
  output logic [7:0]        ar22,
  output logic [7:0]        ar23,
  output logic [7:0]        ar31,
  output logic [7:0]        ar32,
  output logic [7:0]        ar33,
  input  logic [7:0]        k_res,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;

  logic              vld_p0, vld_p1;
  logic [RW-1:0]     r_p0, r_p1;
  logic [CW-1:0]     c_p0, c_p1;
  logic [7:0]        lb0 [IMG_W];
  logic [7:0]        lb1 [IMG_W];
  logic [2:0][2:0][7:0] win;

  logic              wb;
  logic [ADDR_W-1:0] wb_addr;

  // Stage p0: issue reads. idx doubles as clear address, read address and drain count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      r     <= '0;
      c     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLEAR;
            idx   <= '0;
          end
        end
        S_CLEAR: begin
          if (idx == N_LAST) begin
            state <= S_READ;
            idx   <= '0;
            r     <= '0;
            c     <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        S_READ: begin
          if (idx == N_LAST) begin
            state <= S_DRAIN;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
            if (c == C_LAST) begin
              c <= '0;
              r <= r + RW'(1);
            end else begin
              c <= c + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (idx == ADDR_W'(1)) state <= S_FIN;
          else                   idx   <= idx + ADDR_W'(1);
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: pixel arrives from BRAM, window shifts, line buffers update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      win    <= '0;
    end else begin
      vld_p0 <= (state == S_READ);
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1[c_p0];
        win[1][2] <= lb0[c_p0];
        win[2][2] <= src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_p0 <= r;
    c_p0 <= c;
    r_p1 <= r_p0;
    c_p1 <= c_p0;
    if (vld_p0) begin
      lb1[c_p0] <= lb0[c_p0];
      lb0[c_p0] <= src_data;
    end
  end

  // Stage p1: window valid; only fully in-frame windows (r>=2, c>=2) are written back.
  assign wb      = vld_p1 && (r_p1 >= RW'(2)) && (c_p1 >= CW'(2));
  assign wb_addr = (ADDR_W'(r_p1) - ADDR_W'(1)) * W_A + ADDR_W'(c_p1) - ADDR_W'(1);

  assign busy     = (state == S_CLEAR) || (state == S_READ) || (state == S_DRAIN);
  assign done     = (state == S_FIN);
  assign src_en   = (state == S_READ);
  assign src_addr = src_en ? idx : '0;
  assign dst_we   = (state == S_CLEAR) || wb;
  assign dst_addr = (state == S_CLEAR) ? idx : (wb ? wb_addr : '0);
  assign dst_data = wb ? k_res : 8'd0;

  assign ar11 = win[0][0];
  assign ar12 = win[0][1];
  assign ar13 = win[0][2];
  assign ar21 = win[1][0];
  assign ar22 = win[1][1];
  assign ar23 = win[1][2];
  assign ar31 = win[2][0];
  assign ar32 = win[2][1];
  assign ar33 = win[2][2];

endmodule

// File: tb/tb_edge_frame_sched.sv
// Bench for edge_frame_sched: 4x4 and 5x3 instances with BRAM and Sobel-threshold
// kernel models, checked against a frame-level reference of the expected result image.
module tb_edge_frame_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  logic             start_a, busy_a, done_a, src_en_a, dst_we_a;
  logic [7:0]       src_addr_a, dst_addr_a, src_data_a, dst_data_a, k_res_a;
  logic [8:0][7:0]  ar_a;
  logic             start_b, busy_b, done_b, src_en_b, dst_we_b;
  logic [7:0]       src_addr_b, dst_addr_b, src_data_b, dst_data_b, k_res_b;
  logic [8:0][7:0]  ar_b;

  logic [7:0] src_a [16];
  logic [7:0] dst_a [16];
  logic [7:0] src_b [15];
  logic [7:0] dst_b [15];

  edge_frame_sched #(.IMG_W(4), .IMG_H(4), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .src_en(src_en_a), .src_addr(src_addr_a), .src_data(src_data_a),
    .ar11(ar_a[0]), .ar12(ar_a[1]), .ar13(ar_a[2]),
    .ar21(ar_a[3]), .ar22(ar_a[4]), .ar23(ar_a[5]),
    .ar31(ar_a[6]), .ar32(ar_a[7]), .ar33(ar_a[8]),
    .k_res(k_res_a), .dst_we(dst_we_a), .dst_addr(dst_addr_a), .dst_data(dst_data_a)
  );

  edge_frame_sched #(.IMG_W(5), .IMG_H(3), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .src_en(src_en_b), .src_addr(src_addr_b), .src_data(src_data_b),
    .ar11(ar_b[0]), .ar12(ar_b[1]), .ar13(ar_b[2]),
    .ar21(ar_b[3]), .ar22(ar_b[4]), .ar23(ar_b[5]),
    .ar31(ar_b[6]), .ar32(ar_b[7]), .ar33(ar_b[8]),
    .k_res(k_res_b), .dst_we(dst_we_b), .dst_addr(dst_addr_b), .dst_data(dst_data_b)
  );

  // Sobel magnitude |gx|+|gy| thresholded at 128; byte k of p is window row k/3, column k%3.
  function automatic logic [7:0] kern(input logic [71:0] p);
    int gx, gy;
    gx = int'(p[23:16]) + 2 * int'(p[47:40]) + int'(p[71:64])
       - int'(p[7:0])   - 2 * int'(p[31:24]) - int'(p[55:48]);
    gy = int'(p[55:48]) + 2 * int'(p[63:56]) + int'(p[71:64])
       - int'(p[7:0])   - 2 * int'(p[15:8])  - int'(p[23:16]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy >= 128) ? 8'd255 : 8'd0;
  endfunction

  assign k_res_a = kern(ar_a);
  assign k_res_b = kern(ar_b);

  always @(posedge clk) begin
    if (src_en_a) src_data_a <= src_a[src_addr_a[3:0]];
    if (dst_we_a) dst_a[dst_addr_a[3:0]] <= dst_data_a;
    if (src_en_b) src_data_b <= src_b[src_addr_b[3:0]];
    if (dst_we_b) dst_b[dst_addr_b[3:0]] <= dst_data_b;
  end

  function automatic logic [7:0] pix(input bit b, input int a);
    return b ? src_b[a] : src_a[a];
  endfunction

  function automatic logic [71:0] nbr(input bit b, input int w, input int r, input int c);
    logic [71:0] p;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        p[8*(dr*3+dc) +: 8] = pix(b, (r - 1 + dr) * w + c - 1 + dc);
    return p;
  endfunction

  // Expected result image: border pixels 0, interior = kernel of the 3x3 neighbourhood.
  function automatic logic [7:0] ref_px(input bit b, input int w, input int h, input int a);
    int r, c;
    r = a / w;
    c = a % w;
    if (r == 0 || c == 0 || r == h - 1 || c == w - 1) return 8'd0;
    return kern(nbr(b, w, r, c));
  endfunction

  int busy_cnt_a = 0, done_cnt_a = 0, viol_a = 0, n_rd_a = 0, first_rd_a = 0, last_clr_a = 0;
  bit seen_rd_a = 0;
  int rd_cyc_a [16];
  int clr_addr_a[$], clr_data_a[$], wb_addr_a[$], wb_data_a[$], wb_cyc_a[$];
  logic [71:0] wb_ar_a[$];
  int busy_cnt_b = 0, done_cnt_b = 0;
  bit seen_rd_b = 0;
  int wb_addr_b[$], wb_data_b[$];

  // Monitor: logs restart on an accepted start; observations are taken on the falling edge.
  always @(clk) begin
    if (clk) begin
      cyc++;
      if (start_a && !busy_a && !done_a) begin
        busy_cnt_a = 0; done_cnt_a = 0; viol_a = 0; n_rd_a = 0; seen_rd_a = 0;
        clr_addr_a.delete(); clr_data_a.delete();
        wb_addr_a.delete(); wb_data_a.delete(); wb_cyc_a.delete(); wb_ar_a.delete();
      end
      if (start_b && !busy_b && !done_b) begin
        busy_cnt_b = 0; done_cnt_b = 0; seen_rd_b = 0;
        wb_addr_b.delete(); wb_data_b.delete();
      end
    end else begin
      if ((src_en_a || dst_we_a) && !busy_a) viol_a++;
      if (busy_a) busy_cnt_a++;
      if (done_a) done_cnt_a++;
      if (src_en_a) begin
        if (!seen_rd_a) first_rd_a = cyc;
        seen_rd_a = 1;
        rd_cyc_a[src_addr_a[3:0]] = cyc;
        n_rd_a++;
      end
      if (dst_we_a) begin
        if (!seen_rd_a) begin
          clr_addr_a.push_back(int'(dst_addr_a));
          clr_data_a.push_back(int'(dst_data_a));
          last_clr_a = cyc;
        end else begin
          wb_addr_a.push_back(int'(dst_addr_a));
          wb_data_a.push_back(int'(dst_data_a));
          wb_cyc_a.push_back(cyc);
          wb_ar_a.push_back(ar_a);
        end
      end
      if (busy_b) busy_cnt_b++;
      if (done_b) done_cnt_b++;
      if (src_en_b) seen_rd_b = 1;
      if (dst_we_b && seen_rd_b) begin
        wb_addr_b.push_back(int'(dst_addr_b));
        wb_data_b.push_back(int'(dst_data_b));
      end
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  int st_a, st_b;

  // Pulses start at the current falling edge; optional extra start pulse mid-run.
  task automatic frame_a(input string pre, input int mid);
    st_a = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (done_a) break;
      start_a = (k == mid);
      @(negedge clk);
    end
    start_a = 1'b0;
    chk({pre, "_done_seen"}, done_a, 1);
    chk({pre, "_done_lat"}, cyc - st_a, 35);
    @(negedge clk);
  endtask

  task automatic check_a(input string pre);
    bit ok;
    int a;
    chk({pre, "_busy_cycles"}, busy_cnt_a, 34);
    chk({pre, "_done_pulses"}, done_cnt_a, 1);
    chk({pre, "_idle_activity"}, viol_a, 0);
    chk({pre, "_reads"}, n_rd_a, 16);
    chk({pre, "_clear_writes"}, clr_addr_a.size(), 16);
    ok = 1;
    foreach (clr_addr_a[i]) if (clr_addr_a[i] != i || clr_data_a[i] != 0) ok = 0;
    chk({pre, "_clear_seq"}, ok, 1);
    chk({pre, "_clear_then_read"}, first_rd_a > last_clr_a, 1);
    chk({pre, "_wb_count"}, wb_addr_a.size(), 4);
    for (int i = 0; i < 4 && i < wb_addr_a.size(); i++) begin
      a = (1 + i / 2) * 4 + 1 + i % 2;
      chk({pre, "_wb_addr"}, wb_addr_a[i], a);
      chk({pre, "_wb_data"}, wb_data_a[i], ref_px(0, 4, 4, a));
      chk({pre, "_wb_latency"}, wb_cyc_a[i], rd_cyc_a[a + 5] + 2);
    end
    for (int i = 0; i < 16; i++) chk({pre, "_dst_mem"}, dst_a[i], ref_px(0, 4, 4, i));
  endtask

  int sv_addr[$], sv_data[$], sv_rel[$];

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_src_en", src_en_a, 0);
    chk("rst_dst_we", dst_we_a, 0);
    chk("rst_src_addr", src_addr_a, 0);
    chk("rst_dst_addr", dst_addr_a, 0);
    chk("rst_dst_data", dst_data_a, 0);
    chk("rst_window", ar_a, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) src_a[i] = 8'(i);
    frame_a("ramp", 0);
    check_a("ramp");
    chk("ramp_first_window", wb_ar_a[0],
        {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});

    for (int i = 0; i < 16; i++) src_a[i] = 8'd100;
    frame_a("const", 0);
    check_a("const");

    for (int i = 0; i < 16; i++) src_a[i] = 8'($urandom);
    frame_a("midstart", 10);
    check_a("midstart");

    for (int i = 0; i < 15; i++) src_b[i] = (i % 5 == 0) ? 8'd255 : 8'd0;
    st_b = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (done_b) break;
      @(negedge clk);
    end
    chk("wrap_done_lat", cyc - st_b, 33);
    @(negedge clk);
    chk("wrap_busy_cycles", busy_cnt_b, 32);
    chk("wrap_done_pulses", done_cnt_b, 1);
    chk("wrap_wb_count", wb_addr_b.size(), 3);
    for (int i = 0; i < 3 && i < wb_addr_b.size(); i++) begin
      chk("wrap_wb_addr", wb_addr_b[i], 6 + i);
      chk("wrap_wb_data", wb_data_b[i], ref_px(1, 5, 3, 6 + i));
    end
    for (int i = 0; i < 15; i++) chk("wrap_dst_mem", dst_b[i], ref_px(1, 5, 3, i));

    for (int i = 0; i < 16; i++) src_a[i] = 8'($urandom);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (src_en_a && src_addr_a == 8'd7) break;
      @(negedge clk);
    end
    chk("abort_reached_addr7", src_en_a && src_addr_a == 8'd7, 1);
    rst = 1'b1;
    #1;
    chk("abort_src_en", src_en_a, 0);
    chk("abort_dst_we", dst_we_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt_a, 0);
    for (int i = 0; i < 16; i++) src_a[i] = 8'($urandom);
    frame_a("after_rst", 0);
    check_a("after_rst");

    for (int i = 0; i < 16; i++) src_a[i] = 8'($urandom);
    frame_a("b2b_first", 0);
    check_a("b2b_first");
    sv_addr = wb_addr_a;
    sv_data = wb_data_a;
    sv_rel.delete();
    foreach (wb_cyc_a[i]) sv_rel.push_back(wb_cyc_a[i] - st_a);
    frame_a("b2b_second", 0);
    check_a("b2b_second");
    chk("b2b_count", wb_addr_a.size(), sv_addr.size());
    for (int i = 0; i < wb_addr_a.size() && i < sv_addr.size(); i++) begin
      chk("b2b_addr", wb_addr_a[i], sv_addr[i]);
      chk("b2b_data", wb_data_a[i], sv_data[i]);
      chk("b2b_timing", wb_cyc_a[i] - st_a, sv_rel[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/edge_frame_sched.md
Name: edge_frame_sched

Overview:
- Frame-level sequencer for the combinational 3x3 edge kernel.
- Clears the destination frame buffer, then raster-streams the source frame out of a BRAM with 1-cycle read latency.
- Builds the 3x3 window from two line buffers plus shift registers, presents it on the kernel's nine pixel inputs, and writes the kernel's binary edge result back to the destination BRAM.
- Sits between the source-image BRAM, the kernel instance and the result BRAM; a top-level start/done handshake triggers one frame per run.

Parameters:
- IMG_W, 256, image width in pixels (>=3).
- IMG_H, 256, image height in pixels (>=3).
- ADDR_W, 16, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to process a frame.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the frame is complete.
- src_en  output  1  source BRAM read enable.
- src_addr  output  ADDR_W  source read address, raster order r*IMG_W+c.
- src_data  input  8  source BRAM read data; valid 1 cycle after src_en.
- ar11,ar12,ar13,ar21,ar22,ar23,ar31,ar32,ar33  output  8 each  window to kernel; arRC = row R, column C; ar11 = (r-1,c-1), ar22 = centre, ar33 = (r+1,c+1).
- k_res  input  8  kernel result (0 or 255), combinational from the ar* outputs.
- dst_we  output  1  destination BRAM write enable.
- dst_addr  output  ADDR_W  destination write address.
- dst_data  output  8  destination write data.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, src_en, dst_we = 0; src_addr, dst_addr, dst_data, all ar* = 0; line buffers are not cleared.
- FSM states: IDLE, CLEAR, READ, DRAIN, FIN.
- IDLE: start=1 moves to CLEAR next cycle. Start is ignored in every other state.
- CLEAR: IMG_W*IMG_H cycles. dst_we=1, dst_data=0, dst_addr runs 0..IMG_W*IMG_H-1 at one per cycle. After the last address, moves to READ.
- READ: IMG_W*IMG_H cycles. src_en=1, src_addr runs 0..N-1 at one per cycle with internal counters (r,c). After the last address, moves to DRAIN.
- Pixel arrival: data for (r,c) arrives on src_data one cycle after its read.
  - On that cycle's edge, each window row shifts left by one.
  - New right column = {linebuf1[c], linebuf0[c], src_data}, top to bottom.
  - Then linebuf1[c] <= linebuf0[c] and linebuf0[c] <= src_data.
- Window: ar* outputs are the window registers directly, so they are valid the cycle after arrival. The window is then centred on (r-1,c-1).
- Write-back:
  - Condition: in the cycle the window is valid, r>=2 and c>=2.
  - Action: dst_we=1, dst_addr=(r-1)*IMG_W+(c-1), dst_data=k_res, passed through combinationally.
  - Otherwise dst_we=0.
  - This suppresses row/column wrap-around windows. Border pixels keep the 0 written in CLEAR.
- Latency: exactly 2 cycles from a src_en read to the corresponding dst_we.
- DRAIN: 2 cycles so the last arrival and write-back complete. src_en=0. Then FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Run length: busy is high for exactly 2*IMG_W*IMG_H+2 cycles.
- Counters: (r,c) wrap c at IMG_W-1 to 0 with r+1. No counter ever exceeds N-1. Address arithmetic is unsigned ADDR_W.
- src_en and dst_we are never high during IDLE or FIN. The CLEAR and READ phases never overlap.
- Reset mid-frame: immediate return to IDLE with outputs as at reset; the partial destination frame is left as is. A new start reprocesses the whole frame, and stale line-buffer contents do not affect results because writes are gated on r>=2, c>=2.

Test Plan:
- Ramp frame, IMG_W=IMG_H=4, src pixel = address: the first write is at dst_addr=5 with ar11..ar33 = 0,1,2,4,5,6,8,9,10. Writes occur at addresses 5,6,9,10 only, each 2 cycles after its last source read.
- Constant frame of 100, 4x4, bench kernel model: all 16 destination words are 0. CLEAR writes addresses 0..15 first, then 4 interior writes.
- Handshake, 4x4: busy is high for 34 cycles; done pulses once. A start asserted mid-run is ignored (no restart, same done timing).
- Wrap suppression, IMG_W=5, IMG_H=3, source column 0 = 255, rest 0: dst_we is never asserted while c<2, and exactly 3 interior writes occur (addresses 6,7,8).
- Async reset asserted during READ at address 7, 4x4: dst_we, src_en and busy drop immediately, with no done. A following start completes a correct frame identical to a clean run.
- Back-to-back frames: start on the cycle after done is accepted; the second frame's outputs match the first, bit-exact.
